double_max_reduce: RTL and testbench

- Streaming reduction that returns the IEEE-754 double-precision maximum, and its index, over a frame of input samples.
- It is the max-side counterpart of the min component. It is intended as the sequential consumer of a double stream, e.g. peak detection after double_add/double_mul pipelines.
- Input and output are valid/ready handshaked. One result is produced per frame.

---
 rtl/double_pkg.sv | 27 ++
 rtl/double_gt.sv | 30 +++
 rtl/double_max_reduce.sv | 109 ++++++++++
 tb/tb_double_max_reduce.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/double_pkg.sv
// Shared IEEE-754 double-precision field layout and classification helpers
// used by the double-precision datapath blocks.
package double_pkg;

  localparam int DBL_W  = 64;
  localparam int EXP_W  = 11;
  localparam int MANT_W = 52;

  localparam logic [DBL_W-1:0] DBL_QNAN = 64'h7FF8000000000000;

  function automatic logic sign_of(input logic [DBL_W-1:0] d);
    return d[DBL_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] exp_of(input logic [DBL_W-1:0] d);
    return d[DBL_W-2 -: EXP_W];
  endfunction

  function automatic logic [MANT_W-1:0] mant_of(input logic [DBL_W-1:0] d);
    return d[MANT_W-1:0];
  endfunction

  function automatic logic is_nan(input logic [DBL_W-1:0] d);
    return (exp_of(d) == {EXP_W{1'b1}}) && (mant_of(d) != '0);
  endfunction

endpackage

// File: rtl/double_gt.sv
// Combinational a > b for doubles in sign-magnitude order (+0 > -0).
// NaN operands are not special-cased; callers filter them beforehand.
module double_gt
  import double_pkg::*;
(
  input  logic [DBL_W-1:0] a,
  input  logic [DBL_W-1:0] b,
  output logic             gt
);

  logic                   sa;
  logic                   sb;
  logic [DBL_W-2:0]       mag_a;
  logic [DBL_W-2:0]       mag_b;

  always_comb begin
    sa    = sign_of(a);
    sb    = sign_of(b);
    mag_a = {exp_of(a), mant_of(a)};
    mag_b = {exp_of(b), mant_of(b)};
    gt    = 1'b0;
    if (sa != sb)
      gt = sb;
    else if (!sa)
      gt = mag_a > mag_b;
    else
      gt = mag_a < mag_b;
  end

endmodule

// File: rtl/double_max_reduce.sv
// Streaming per-frame double-precision maximum with index, sample count and
// an all-NaN flag; frames close on FRAME_LEN samples or in_last.
module double_max_reduce
  import double_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DBL_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [DBL_W-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [0:0]       ACC      = 1'b0;
  localparam logic [0:0]       EMIT     = 1'b1;
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN);

  logic [0:0]       state;
  logic [IDX_W-1:0] count;
  logic [DBL_W-1:0] acc_max_p0;
  logic [IDX_W-1:0] acc_idx_p0;
  logic             acc_seen_p0;

  logic             accept;
  logic             smp_nan;
  logic             smp_gt;
  logic             take;
  logic             closing;
  logic [IDX_W-1:0] count_nxt;
  logic [DBL_W-1:0] max_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             seen_nxt;

  double_gt u_gt (
    .a  (in_data),
    .b  (acc_max_p0),
    .gt (smp_gt)
  );

  assign in_ready  = (state == ACC);
  assign out_valid = (state == EMIT);

  // Strict greater-than keeps the earlier index on ties; the first non-NaN
  // sample always wins because nothing has been seen yet.
  always_comb begin
    accept    = in_valid && in_ready;
    smp_nan   = is_nan(in_data);
    take      = !smp_nan && (!acc_seen_p0 || smp_gt);
    count_nxt = count + 1'b1;
    closing   = (count_nxt == LAST_CNT) || in_last;
    max_nxt   = take ? in_data : acc_max_p0;
    idx_nxt   = take ? count : acc_idx_p0;
    seen_nxt  = acc_seen_p0 || !smp_nan;
  end

  // Stage p0: running max while accumulating, result register on close
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACC;
      count       <= '0;
      acc_seen_p0 <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
      out_count   <= '0;
      out_nan     <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (closing) begin
              state       <= EMIT;
              count       <= '0;
              acc_seen_p0 <= 1'b0;
              out_data    <= seen_nxt ? max_nxt : DBL_QNAN;
              out_index   <= seen_nxt ? idx_nxt : '0;
              out_count   <= count_nxt;
              out_nan     <= !seen_nxt;
            end else begin
              count       <= count_nxt;
              acc_seen_p0 <= seen_nxt;
            end
          end
        end
        default: begin
          if (out_ready)
            state <= ACC;
        end
      endcase
    end
  end

  // Running max/index carry no reset; acc_seen_p0 qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_max_p0 <= max_nxt;
      acc_idx_p0 <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_double_max_reduce.sv
// Directed self-checking bench for double_max_reduce.
module tb_double_max_reduce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_index;
  logic [7:0]  out_count;
  logic        out_nan;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [63:0] P1   = 64'h3FF0000000000000;
  localparam logic [63:0] P2   = 64'h4000000000000000;
  localparam logic [63:0] M1   = 64'hBFF0000000000000;
  localparam logic [63:0] M2   = 64'hC000000000000000;
  localparam logic [63:0] PH   = 64'h3FE0000000000000;
  localparam logic [63:0] PZ   = 64'h0000000000000000;
  localparam logic [63:0] MZ   = 64'h8000000000000000;
  localparam logic [63:0] QN   = 64'h7FF8000000000000;
  localparam logic [63:0] SNM  = 64'hFFF0000000000001;
  localparam logic [63:0] NINF = 64'hFFF0000000000000;
  localparam logic [63:0] PINF = 64'h7FF0000000000000;
  localparam logic [63:0] P3   = 64'h4008000000000000;
  localparam logic [63:0] P5   = 64'h4014000000000000;
  localparam logic [63:0] P7   = 64'h401C000000000000;
  localparam logic [63:0] P9   = 64'h4022000000000000;

  always #5 clk = ~clk;

  double_max_reduce #(.FRAME_LEN(8), .IDX_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_count (out_count),
    .out_nan   (out_nan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic send(input logic [63:0] d, input logic last);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL send_ready got in_ready=%0b want 1", in_ready);
    end
    in_data = d; in_valid = 1'b1; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) begin
      total_cnt++;
      $display("FAIL wait_valid got out_valid=0 want 1 within 20 cycles");
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %0b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_data !== 64'h0) $display("FAIL rst_data got %h want 0", out_data); else pass_cnt++;
    total_cnt++; if (out_index !== 8'd0 || out_count !== 8'd0 || out_nan !== 1'b0)
      $display("FAIL rst_outs got idx=%0d cnt=%0d nan=%0b want 0/0/0", out_index, out_count, out_nan); else pass_cnt++;
  endtask

  task automatic test_full_frame();
    send(P1, 1'b0); send(P2, 1'b0); send(M1, 1'b0);
    for (int i = 0; i < 4; i++) send(PH, 1'b0);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL full_early got out_valid=%0b want 0", out_valid); else pass_cnt++;
    send(PH, 1'b0);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL full_latency got out_valid=%0b want 1", out_valid); else pass_cnt++;
    wait_valid();
    total_cnt++; if (out_data !== P2) $display("FAIL full_data got %h want %h", out_data, P2); else pass_cnt++;
    total_cnt++; if (out_index !== 8'd1) $display("FAIL full_index got %0d want 1", out_index); else pass_cnt++;
    total_cnt++; if (out_count !== 8'd8) $display("FAIL full_count got %0d want 8", out_count); else pass_cnt++;
    total_cnt++; if (out_nan !== 1'b0) $display("FAIL full_nan got %0b want 0", out_nan); else pass_cnt++;
    release_result();
  endtask

  task automatic test_short_frame();
    send(M2, 1'b0);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL short_early got out_valid=%0b want 0", out_valid); else pass_cnt++;
    send(M1, 1'b1);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL short_latency got out_valid=%0b want 1", out_valid); else pass_cnt++;
    wait_valid();
    total_cnt++; if (out_data !== M1) $display("FAIL short_data got %h want %h", out_data, M1); else pass_cnt++;
    total_cnt++; if (out_index !== 8'd1 || out_count !== 8'd2)
      $display("FAIL short_idx_cnt got idx=%0d cnt=%0d want 1/2", out_index, out_count); else pass_cnt++;
    release_result();
  endtask

  task automatic test_zero_tie();
    send(MZ, 1'b0); send(PZ, 1'b0); send(PZ, 1'b1);
    wait_valid();
    total_cnt++; if (out_data !== PZ) $display("FAIL zero_data got %h want %h", out_data, PZ); else pass_cnt++;
    total_cnt++; if (out_index !== 8'd1) $display("FAIL zero_index got %0d want 1", out_index); else pass_cnt++;
    total_cnt++; if (out_count !== 8'd3) $display("FAIL zero_count got %0d want 3", out_count); else pass_cnt++;
    release_result();
  endtask

  task automatic test_nan();
    send(QN, 1'b0); send(NINF, 1'b0); send(QN, 1'b1);
    wait_valid();
    total_cnt++; if (out_data !== NINF) $display("FAIL nan1_data got %h want %h", out_data, NINF); else pass_cnt++;
    total_cnt++; if (out_index !== 8'd1 || out_nan !== 1'b0)
      $display("FAIL nan1_idx_flag got idx=%0d nan=%0b want 1/0", out_index, out_nan); else pass_cnt++;
    release_result();
    send(QN, 1'b0); send(SNM, 1'b1);
    wait_valid();
    total_cnt++; if (out_data !== QN) $display("FAIL nan2_data got %h want %h", out_data, QN); else pass_cnt++;
    total_cnt++; if (out_nan !== 1'b1) $display("FAIL nan2_flag got %0b want 1", out_nan); else pass_cnt++;
    total_cnt++; if (out_count !== 8'd2 || out_index !== 8'd0)
      $display("FAIL nan2_cnt_idx got cnt=%0d idx=%0d want 2/0", out_count, out_index); else pass_cnt++;
    release_result();
  endtask

  task automatic test_special();
    send(64'h0000000000000001, 1'b0); send(64'h000FFFFFFFFFFFFF, 1'b0); send(64'h800FFFFFFFFFFFFF, 1'b1);
    wait_valid();
    total_cnt++; if (out_data !== 64'h000FFFFFFFFFFFFF || out_index !== 8'd1)
      $display("FAIL denorm got %h idx=%0d want 000fffffffffffff idx=1", out_data, out_index); else pass_cnt++;
    release_result();
    send(P9, 1'b0); send(PINF, 1'b0); send(PINF, 1'b0); send(P7, 1'b1);
    wait_valid();
    total_cnt++; if (out_data !== PINF || out_index !== 8'd1)
      $display("FAIL inf_tie got %h idx=%0d want %h idx=1", out_data, out_index, PINF); else pass_cnt++;
    release_result();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    send(P7, 1'b0); send(P3, 1'b1);
    wait_valid();
    in_data = P5; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== P7 || out_count !== 8'd2 || out_index !== 8'd0) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got valid=%0b ready=%0b want 0/1", out_valid, in_ready); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(P1, 1'b1);
    wait_valid();
    total_cnt++; if (out_data !== P5 || out_index !== 8'd0 || out_count !== 8'd2)
      $display("FAIL bp_next got %h idx=%0d cnt=%0d want %h idx=0 cnt=2", out_data, out_index, out_count, P5); else pass_cnt++;
    release_result();
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 3; i++) send(P9, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 8'd0)
      $display("FAIL midrst_state got valid=%0b ready=%0b cnt=%0d want 0/1/0", out_valid, in_ready, out_count); else pass_cnt++;
    for (int i = 0; i < 7; i++) send(P1, 1'b0);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_early got out_valid=%0b want 0", out_valid); else pass_cnt++;
    send(P1, 1'b0);
    wait_valid();
    total_cnt++; if (out_data !== P1 || out_count !== 8'd8 || out_index !== 8'd0)
      $display("FAIL midrst_frame got %h cnt=%0d idx=%0d want %h cnt=8 idx=0", out_data, out_count, out_index, P1); else pass_cnt++;
    release_result();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_zero_tie();
    test_nan();
    test_special();
    test_backpressure();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
